// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplication uses shift-add and division uses restoring shift-subtract.
// Each pass retires one bit per cycle.
// Divide-by-zero and signed overflow results are produced directly at accept.
//
// state | meaning
// IDLE  | waiting for start; ready=1
// CALC  | one shift-add / shift-subtract iteration per cycle
// FIX   | sign correction, result register written
// DONE  | done=1 for one cycle
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic              sa;
  logic              sb;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;     // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]   opnd;    // multiplicand or divisor magnitude

  logic              in_sa;
  logic              in_sb;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              fast;
  logic [XLEN-1:0]   fast_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     trial;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_res;

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  // Accept-time decode: operand signs, magnitudes and the fast-path result.
  always_comb begin
    in_sa    = a[XLEN-1] & ((op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM));
    in_sb    = b[XLEN-1] & ((op == OP_MULH) | (op == OP_DIV) | (op == OP_REM));
    mag_a    = in_sa ? (~a + 1'b1) : a;
    mag_b    = in_sb ? (~b + 1'b1) : b;
    fast     = 1'b0;
    fast_res = '0;
    if (op[2] && (b == '0)) begin
      fast     = 1'b1;
      fast_res = op[1] ? a : '1;
    end else if (((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1)) begin
      fast     = 1'b1;
      fast_res = op[1] ? '0 : a;
    end
  end

  // One iteration of shift-add (multiply) and restoring shift-subtract (divide).
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc[XLEN-1:1]};
    trial    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff     = trial - {1'b0, opnd};
    if (diff[XLEN])
      div_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      div_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  // Final sign correction and result selection.
  always_comb begin
    prod    = (sa ^ sb) ? (~acc + 1'b1) : acc;
    quo     = acc[XLEN-1:0];
    rem     = acc[2*XLEN-1:XLEN];
    fix_res = '0;
    case (op_q)
      OP_MUL:                        fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV:                        fix_res = (sa ^ sb) ? (~quo + 1'b1) : quo;
      OP_DIVU:                       fix_res = quo;
      OP_REM:                        fix_res = sa ? (~rem + 1'b1) : rem;
      OP_REMU:                       fix_res = rem;
      default:                       fix_res = '0;
    endcase
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !kill) begin
            op_q <= op;
            sa   <= in_sa;
            sb   <= in_sb;
            cnt  <= CW'(XLEN - 1);
            if (fast) begin
              result <= fast_res;
              state  <= DONE;
            end else begin
              // multiplier and dividend both sit in the low half of acc
              acc   <= {{XLEN{1'b0}}, op[2] ? mag_a : mag_b};
              opnd  <= op[2] ? mag_b : mag_a;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (kill) begin
            state <= IDLE;
          end else begin
            acc <= op_q[2] ? div_next : mul_next;
            cnt <= cnt - 1'b1;
            if (cnt == '0)
              state <= FIX;
          end
        end
        FIX: begin
          if (!kill)
            result <= fix_res;
          state <= kill ? IDLE : DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32 and XLEN=8.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, kill, start8, kill8;
  logic [2:0]  op, op8;
  logic [31:0] a, b, res;
  logic [7:0]  a8, b8, res8;
  logic        ready, done, ready8, done8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .kill(kill), .ready(ready), .done(done), .result(res)
  );

  muldiv_unit #(.XLEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .kill(kill8), .ready(ready8), .done(done8), .result(res8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, then count cycles until done (n=1 is the cycle after the accept edge).
  task automatic run(input bit w8, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input int exp_lat, input logic [31:0] exp_res, input string tag);
    int n;
    bit seen;
    @(negedge clk);
    if (w8) begin op8 = o; a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1; end
    else    begin op  = o; a  = x;      b  = y;      start  = 1'b1; end
    @(negedge clk);
    start = 1'b0; start8 = 1'b0;
    a = ~x; b = ~y; a8 = ~x[7:0]; b8 = ~y[7:0]; op = ~o; op8 = ~o;
    n = 1;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      if (w8 ? done8 : done) seen = 1'b1;
      else begin @(negedge clk); n++; end
    end
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " result"}, w8 ? {24'b0, res8} : res, exp_res);
  endtask

  initial begin
    int n;
    int bad;
    int dcount;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; start8 = 1'b0; kill8 = 1'b0;
    op = '0; a = '0; b = '0; op8 = '0; a8 = '0; b8 = '0;
    #12;
    chk("reset ready", ready, 1);
    chk("reset done", done, 0);
    chk("reset result", res, 0);
    chk("reset result8", res8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // MUL 7 * -3 with a start pulse during CALC that must be ignored
    @(negedge clk);
    op = 3'b000; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 32'd1; b = 32'd1;
    n = 1; bad = 0;
    while (n < 100 && !done) begin
      if (ready) bad++;
      if (n == 5) begin start = 1'b1; op = 3'b101; end
      if (n == 6) start = 1'b0;
      @(negedge clk); n++;
    end
    chk("mul ready low in flight", bad, 0);
    chk("mul latency", n, 34);
    chk("mul ready during done", ready, 0);
    chk("mul result", res, 32'hFFFF_FFEB);
    @(negedge clk);
    chk("mul ready back", ready, 1);
    chk("mul done one cycle", done, 0);

    run(0, 3'b001, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, "mulh min*min");
    run(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, "mulhu");
    run(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFF, "mulhsu");
    run(0, 3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, "mul min*-1");
    run(0, 3'b100, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, "div -7/2");
    run(0, 3'b110, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, "rem -7/2");
    run(0, 3'b100, 32'd7, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFD, "div 7/-2");
    run(0, 3'b110, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, "rem 7/-2");
    run(0, 3'b100, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, "div by zero");
    run(0, 3'b110, 32'd5, 32'd0, 1, 32'd5, "rem by zero");
    run(0, 3'b101, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, "divu by zero");
    run(0, 3'b111, 32'd5, 32'd0, 1, 32'd5, "remu by zero");
    run(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "div overflow");
    run(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, "rem overflow");
    run(0, 3'b101, 32'd100, 32'd7, 34, 32'd14, "divu 100/7");
    run(0, 3'b111, 32'd100, 32'd7, 34, 32'd2, "remu 100/7");

    // DIVU 100/7 killed at edge 10
    @(negedge clk);
    op = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    for (int i = 1; i < 10; i++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill ready after kill edge", ready, 1);
    @(negedge clk);
    chk("kill ready after edge 11", ready, 1);
    for (int i = 0; i < 40; i++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    chk("kill no done", dcount, 0);
    chk("kill result held", res, 32'd2);

    run(0, 3'b000, 32'd3, 32'd4, 34, 32'd12, "mul 3*4 after kill");

    // kill and start together in IDLE
    @(negedge clk);
    op = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("kill+start ready", ready, 1);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || !ready) dcount++;
      @(negedge clk);
    end
    chk("kill+start no accept", dcount, 0);
    chk("kill+start result", res, 32'd12);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    op = 3'b000; a = 32'd5; b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset ready", ready, 1);
    chk("async reset done", done, 0);
    chk("async reset result", res, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(1, 3'b011, 32'hFF, 32'hFF, 10, 32'hFE, "x8 mulhu");
    run(1, 3'b100, 32'h80, 32'hFF, 1, 32'h80, "x8 div overflow");
    run(1, 3'b100, 32'hF9, 32'h02, 10, 32'hFD, "x8 div -7/2");
    run(1, 3'b000, 32'h07, 32'hFD, 10, 32'hEB, "x8 mul 7*-3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
